// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer
// Turns the GMII receive signals into a framed byte stream for the MAC RX
// path. The preamble and SFD are removed, and frame length is checked
// against MIN_FRAME_LEN/MAX_FRAME_LEN. A GMII receive error inside a frame
// marks that frame bad. Wrapping statistics counters are kept.
//
// Ports:
//   clk        GMII receive clock, rising edge
//   reset      synchronous active-high reset
//   rx_dv      GMII receive data valid
//   rxd[7:0]   GMII receive data
//   rx_er      GMII receive error
//   out_valid  out_data carries a frame byte
//   out_data   frame byte, destination MAC first, FCS last
//   out_sop    first byte of a frame (with out_valid)
//   out_eop    last byte of a frame (with out_valid)
//   out_err    frame is bad (meaningful with out_eop)
//   out_len    frame byte count (meaningful with out_eop)
//   frame_cnt  good frames emitted
//   err_cnt    bad frames emitted
//   drop_cnt   frames discarded without any output
module gmii_rx_deframer #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1522
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rxd,
  input  logic        rx_er,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic [15:0] out_len,
  output logic [31:0] frame_cnt,
  output logic [31:0] err_cnt,
  output logic [31:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [15:0] MinLen = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MaxLen = 16'(MAX_FRAME_LEN);
  localparam logic [7:0]  PreambleByte = 8'h55;
  localparam logic [7:0]  SfdByte = 8'hD5;

  state_t      state;
  logic [7:0]  hold_data;
  logic        hold_valid;
  logic        hold_sop;
  logic        err_flag;
  logic [15:0] len;
  logic        end_bad;

  // Verdict for a frame ending normally: a sticky receive error or a runt.
  assign end_bad = err_flag || (len < MinLen);

  // One byte is held back so that the frame end, which is only seen when
  // rx_dv drops, can be flagged on the last real byte. len counts the bytes
  // taken into the hold register, so it equals the number of bytes emitted
  // once the held byte goes out as eop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DROP;
      hold_data  <= 8'h00;
      hold_valid <= 1'b0;
      hold_sop   <= 1'b0;
      err_flag   <= 1'b0;
      len        <= 16'h0000;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_err    <= 1'b0;
      out_len    <= 16'h0000;
      frame_cnt  <= 32'h0;
      err_cnt    <= 32'h0;
      drop_cnt   <= 32'h0;
    end else begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      out_len   <= 16'h0000;

      case (state)
        IDLE: begin
          if (rx_dv) begin
            if (rx_er) begin
              drop_cnt <= drop_cnt + 32'd1;
              state    <= DROP;
            end else if (rxd == PreambleByte) begin
              state <= PRE;
            end else if (rxd == SfdByte) begin
              state <= DATA;
            end else begin
              drop_cnt <= drop_cnt + 32'd1;
              state    <= DROP;
            end
          end
        end

        PRE: begin
          if (!rx_dv) begin
            drop_cnt <= drop_cnt + 32'd1;
            state    <= IDLE;
          end else if (rx_er) begin
            drop_cnt <= drop_cnt + 32'd1;
            state    <= DROP;
          end else if (rxd == SfdByte) begin
            state <= DATA;
          end else if (rxd != PreambleByte) begin
            drop_cnt <= drop_cnt + 32'd1;
            state    <= DROP;
          end
        end

        DATA: begin
          if (rx_dv && (len == MaxLen)) begin
            // Giant: the incoming byte would exceed the limit, so the held
            // byte closes the frame and the rest is discarded.
            out_valid  <= 1'b1;
            out_data   <= hold_data;
            out_sop    <= hold_sop;
            out_eop    <= 1'b1;
            out_err    <= 1'b1;
            out_len    <= len;
            err_cnt    <= err_cnt + 32'd1;
            hold_valid <= 1'b0;
            err_flag   <= 1'b0;
            len        <= 16'h0000;
            state      <= DROP;
          end else if (rx_dv) begin
            if (hold_valid) begin
              out_valid <= 1'b1;
              out_data  <= hold_data;
              out_sop   <= hold_sop;
            end
            hold_data  <= rxd;
            hold_valid <= 1'b1;
            hold_sop   <= !hold_valid;
            err_flag   <= err_flag || rx_er;
            len        <= len + 16'd1;
          end else begin
            if (hold_valid) begin
              out_valid <= 1'b1;
              out_data  <= hold_data;
              out_sop   <= hold_sop;
              out_eop   <= 1'b1;
              out_err   <= end_bad;
              out_len   <= len;
              if (end_bad) err_cnt <= err_cnt + 32'd1;
              else         frame_cnt <= frame_cnt + 32'd1;
            end else begin
              // SFD immediately followed by end of carrier: empty frame.
              drop_cnt <= drop_cnt + 32'd1;
            end
            hold_valid <= 1'b0;
            err_flag   <= 1'b0;
            len        <= 16'h0000;
            state      <= IDLE;
          end
        end

        DROP: begin
          if (!rx_dv) state <= IDLE;
        end

        default: state <= DROP;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// tb_gmii_rx_deframer
// Drives directed GMII frames into gmii_rx_deframer. Each frame task works
// out from frame-level rules (length limits, error position, 2-cycle
// latency) which output beat must appear after which clock edge. A single
// compare process checks every cycle against those expectations. Literal
// values after each scenario pin the expectations themselves.
module tb_gmii_rx_deframer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_dv;
  logic [7:0]  rxd;
  logic        rx_er;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_err;
  logic [15:0] out_len;
  logic [31:0] frame_cnt;
  logic [31:0] err_cnt;
  logic [31:0] drop_cnt;

  gmii_rx_deframer #(
    .MIN_FRAME_LEN(MIN_LEN),
    .MAX_FRAME_LEN(MAX_LEN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_dv(rx_dv),
    .rxd(rxd),
    .rx_er(rx_er),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .out_err(out_err),
    .out_len(out_len),
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  data;
    logic        sop;
    logic        eop;
    logic        err;
    logic [15:0] len;
  } beat_t;

  // Expected beats keyed by the rising-edge number after which they show.
  beat_t exp_beats [int];

  int edge_num = 0;
  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  int exp_frames = 0;
  int exp_errs = 0;
  int exp_drops = 0;

  int          mon_beats = 0;
  logic [7:0]  mon_first = 8'h00;
  logic [7:0]  mon_last = 8'h00;
  logic [15:0] mon_len = 16'h0000;
  logic        mon_err = 1'b0;
  logic        mon_eop_sop = 1'b0;

  always @(posedge clk) edge_num <= edge_num + 1;

  // Compare every cycle against the expected beats, and record frame-level
  // observations for the literal checks.
  always @(negedge clk) begin : compare
    beat_t exp_b;
    beat_t act_b;
    if (checking) begin
      checks++;
      act_b.data = out_data;
      act_b.sop  = out_sop;
      act_b.eop  = out_eop;
      act_b.err  = out_eop ? out_err : 1'b0;
      act_b.len  = out_eop ? out_len : 16'h0000;
      if (exp_beats.exists(edge_num)) begin
        exp_b = exp_beats[edge_num];
        exp_beats.delete(edge_num);
        if (out_valid !== 1'b1 || act_b !== exp_b) begin
          errors++;
          $display("[TB] FAIL beat edge=%0d valid=%b actual=%h required=%h (data,sop,eop,err,len)",
                   edge_num, out_valid, act_b, exp_b);
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle edge=%0d out_valid actual=%b required=0 data=%h",
                 edge_num, out_valid, out_data);
      end
    end
    if (out_valid === 1'b1) begin
      if (out_sop === 1'b1) begin
        mon_beats = 1;
        mon_first = out_data;
      end else begin
        mon_beats++;
      end
      if (out_eop === 1'b1) begin
        mon_last    = out_data;
        mon_len     = out_len;
        mon_err     = out_err;
        mon_eop_sop = out_sop;
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic dv, input logic [7:0] d,
                               input logic er, output int sample_edge);
    @(negedge clk);
    reset = rst;
    rx_dv = dv;
    rxd   = d;
    rx_er = er;
    sample_edge = edge_num + 1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic idle(input int n);
    int s;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, s);
  endtask

  task automatic checkCounters();
    checkOutput("frame_cnt model", frame_cnt, 32'(exp_frames));
    checkOutput("err_cnt model", err_cnt, 32'(exp_errs));
    checkOutput("drop_cnt model", drop_cnt, 32'(exp_drops));
  endtask

  // Preamble, SFD, n_data bytes (seed, seed+1, ...), then one rx_dv=0 cycle.
  // er_idx < 0 means no receive error inside the frame.
  task automatic sendFrame(input int n_pre, input int n_data, input int er_idx,
                           input logic [7:0] seed);
    int s;
    int k;
    logic bad;
    logic [7:0] d;
    beat_t b;
    k   = (n_data > MAX_LEN) ? MAX_LEN : n_data;
    bad = (n_data > MAX_LEN) || (n_data < MIN_LEN) || (er_idx >= 0 && er_idx < k);
    for (int i = 0; i < n_pre; i++) applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, s);
    applyStimulus(1'b0, 1'b1, 8'hD5, 1'b0, s);
    for (int i = 0; i < n_data; i++) begin
      d = seed + 8'(i);
      applyStimulus(1'b0, 1'b1, d, (i == er_idx), s);
      if (i < k) begin
        b.data = d;
        b.sop  = (i == 0);
        b.eop  = (i == k - 1);
        b.err  = (i == k - 1) ? bad : 1'b0;
        b.len  = (i == k - 1) ? 16'(k) : 16'h0000;
        exp_beats[s + 1] = b;
      end
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, s);
    if (n_data == 0) exp_drops++;
    else if (bad)    exp_errs++;
    else             exp_frames++;
  endtask

  initial begin : stimulus
    int s;
    beat_t b;
    reset = 1'b1;
    rx_dv = 1'b0;
    rxd   = 8'h00;
    rx_er = 1'b0;

    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, s);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, s);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_sop/eop/err", {29'd0, out_sop, out_eop, out_err}, 32'd0);
    checkOutput("reset out_len", 32'(out_len), 32'd0);
    checkOutput("reset frame_cnt", frame_cnt, 32'd0);
    checkOutput("reset err_cnt", err_cnt, 32'd0);
    checkOutput("reset drop_cnt", drop_cnt, 32'd0);
    checking = 1'b1;
    idle(2);

    $display("[TB] good 64-byte frame");
    sendFrame(7, 64, -1, 8'h00);
    idle(3);
    checkOutput("good frame_cnt", frame_cnt, 32'd1);
    checkOutput("good beats", 32'(mon_beats), 32'd64);
    checkOutput("good first byte", 32'(mon_first), 32'h00);
    checkOutput("good last byte", 32'(mon_last), 32'h3F);
    checkOutput("good len", 32'(mon_len), 32'd64);
    checkOutput("good err", 32'(mon_err), 32'd0);
    checkCounters();

    $display("[TB] frame with rx_er on byte 10");
    sendFrame(7, 64, 10, 8'h00);
    idle(3);
    checkOutput("rxer err_cnt", err_cnt, 32'd1);
    checkOutput("rxer frame_cnt", frame_cnt, 32'd1);
    checkOutput("rxer beats", 32'(mon_beats), 32'd64);
    checkOutput("rxer err", 32'(mon_err), 32'd1);
    checkCounters();

    $display("[TB] runt frames");
    sendFrame(7, 20, -1, 8'h40);
    idle(3);
    checkOutput("runt len", 32'(mon_len), 32'd20);
    checkOutput("runt err", 32'(mon_err), 32'd1);
    sendFrame(3, 1, -1, 8'hA5);
    idle(3);
    checkOutput("one-byte beats", 32'(mon_beats), 32'd1);
    checkOutput("one-byte sop with eop", 32'(mon_eop_sop), 32'd1);
    checkOutput("one-byte err", 32'(mon_err), 32'd1);
    checkOutput("one-byte data", 32'(mon_last), 32'hA5);
    checkCounters();

    $display("[TB] giant frame then normal frame");
    sendFrame(7, 1600, -1, 8'h00);
    idle(3);
    checkOutput("giant len", 32'(mon_len), 32'd1522);
    checkOutput("giant beats", 32'(mon_beats), 32'd1522);
    checkOutput("giant err", 32'(mon_err), 32'd1);
    checkOutput("giant err_cnt", err_cnt, 32'd4);
    sendFrame(7, 64, -1, 8'h10);
    idle(3);
    checkOutput("after giant frame_cnt", frame_cnt, 32'd2);
    checkOutput("after giant first byte", 32'(mon_first), 32'h10);
    checkCounters();

    $display("[TB] dropped frames");
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, s);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, s);
    applyStimulus(1'b0, 1'b1, 8'h5D, 1'b0, s);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0, s);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, s);
    exp_drops++;
    idle(3);
    checkOutput("bad preamble drop_cnt", drop_cnt, 32'd1);
    sendFrame(7, 0, -1, 8'h00);
    idle(3);
    checkOutput("empty frame drop_cnt", drop_cnt, 32'd2);
    checkCounters();

    $display("[TB] false carrier then back-to-back frames");
    applyStimulus(1'b0, 1'b0, 8'h0E, 1'b1, s);
    applyStimulus(1'b0, 1'b0, 8'h0E, 1'b1, s);
    sendFrame(7, 64, -1, 8'h20);
    sendFrame(7, 64, -1, 8'h60);
    idle(3);
    checkOutput("b2b frame_cnt", frame_cnt, 32'd4);
    checkOutput("b2b last byte", 32'(mon_last), 32'h9F);
    checkCounters();

    $display("[TB] reset in the middle of a frame");
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, s);
    applyStimulus(1'b0, 1'b1, 8'hD5, 1'b0, s);
    for (int i = 0; i < 50; i++) begin
      applyStimulus((i == 30), 1'b1, 8'(i), 1'b0, s);
      if (i < 29) begin
        b.data = 8'(i);
        b.sop  = (i == 0);
        b.eop  = 1'b0;
        b.err  = 1'b0;
        b.len  = 16'h0000;
        exp_beats[s + 1] = b;
      end
      if (i == 30) begin
        exp_frames = 0;
        exp_errs   = 0;
        exp_drops  = 0;
      end
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, s);
    idle(3);
    checkOutput("post-reset frame_cnt", frame_cnt, 32'd0);
    checkOutput("post-reset err_cnt", err_cnt, 32'd0);
    checkOutput("post-reset drop_cnt", drop_cnt, 32'd0);
    sendFrame(7, 64, -1, 8'h80);
    idle(3);
    checkOutput("recovered frame_cnt", frame_cnt, 32'd1);
    checkOutput("recovered len", 32'(mon_len), 32'd64);
    checkCounters();

    checkOutput("pending beats", 32'(exp_beats.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
